weight_slice_packer: RTL and testbench

- Write-side feeder for the float16 weight RAM.
- Accepts a serial stream of 16-bit float weights over a valid/ready handshake.
- Packs each kernel slice of ks*ks values into the 25-slot (5x5) slice bus, then issues one write per slice (ena_wr, addr_write, din) at consecutive slice addresses.
- Sits between the off-chip/DMA weight stream and the RAM write port, so the RAM read side is only disturbed during single-cycle write pulses.

---
 rtl/weight_slice_packer_pkg.sv | 24 ++
 rtl/weight_slice_packer_if.sv | 29 ++
 rtl/weight_slice_packer_fp16_nan_flush.sv | 16 +
 rtl/weight_slice_packer.sv | 144 ++++++++++++++
 tb/tb_weight_slice_packer.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/weight_slice_packer_pkg.sv
// Shared constants, FSM encoding and fp16 helpers for the weight slice packer.
// The constants are also used by the float16 weight RAM.
package weight_slice_packer_pkg;

  localparam int DATA_WIDTH       = 16;
  localparam int KERNEL_SIZE_MAX  = 5;
  localparam int WRITE_ADDR_WIDTH = 5;
  localparam int SLICE_MAX        = 4;
  localparam int SLOTS            = KERNEL_SIZE_MAX * KERNEL_SIZE_MAX;
  localparam int DIN_WIDTH        = SLOTS * DATA_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // fp16 NaN: all-ones exponent with a non-zero mantissa (infinities excluded)
  function automatic logic is_fp16_nan(input logic [15:0] value);
    return (value[14:10] == 5'h1F) && (value[9:0] != 10'd0);
  endfunction

endpackage

// File: rtl/weight_slice_packer_if.sv
// Job control, weight stream and RAM write-port signals of the slice packer.
// master = job/stream source side, slave = the packer itself.
interface weight_slice_packer_if;
  import weight_slice_packer_pkg::*;

  logic                        start;
  logic [2:0]                  kernel_size;
  logic [WRITE_ADDR_WIDTH-1:0] slice_count;
  logic                        w_valid;
  logic [DATA_WIDTH-1:0]       w_data;
  logic                        w_ready;
  logic                        ena_wr;
  logic [WRITE_ADDR_WIDTH-1:0] addr_write;
  logic [DIN_WIDTH-1:0]        din;
  logic                        busy;
  logic                        done;
  logic                        nan_seen;

  modport master (
    output start, kernel_size, slice_count, w_valid, w_data,
    input  w_ready, ena_wr, addr_write, din, busy, done, nan_seen
  );

  modport slave (
    input  start, kernel_size, slice_count, w_valid, w_data,
    output w_ready, ena_wr, addr_write, din, busy, done, nan_seen
  );

endinterface

// File: rtl/weight_slice_packer_fp16_nan_flush.sv
// Combinational fp16 NaN detect/replace; only built with WEIGHT_PACK_NAN_FLUSH_EN.
// Infinities pass through untouched; NaNs become +0.
`ifdef WEIGHT_PACK_NAN_FLUSH_EN
module fp16_nan_flush
  import weight_slice_packer_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] word,
  output logic [DATA_WIDTH-1:0] clean,
  output logic                  nan
);

  assign nan   = is_fp16_nan(word);
  assign clean = nan ? 16'h0000 : word;

endmodule
`endif

// File: rtl/weight_slice_packer.sv
// Packs a serial fp16 weight stream into 5x5 slice words and writes one slice per cycle pulse.
// Optional NaN flushing is enabled by defining WEIGHT_PACK_NAN_FLUSH_EN.
module weight_slice_packer
  import weight_slice_packer_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  weight_slice_packer_if.slave bus
);

  state_t                      state;
  state_t                      next_state;
  logic [2:0]                  ks;
  logic [WRITE_ADDR_WIDTH-1:0] slices;
  logic [WRITE_ADDR_WIDTH-1:0] slice_idx;
  logic [4:0]                  elem_cnt;
  logic [4:0]                  slot_total;
  logic [DIN_WIDTH-1:0]        buffer;
  logic [DIN_WIDTH-1:0]        buffer_next;
  logic [DATA_WIDTH-1:0]       word;
  logic                        word_nan;
  logic                        cfg_ok;
  logic                        accept;
  logic                        last_word;
  logic                        last_slice;

`ifdef WEIGHT_PACK_NAN_FLUSH_EN
  fp16_nan_flush u_nan_flush (
    .word  (bus.w_data),
    .clean (word),
    .nan   (word_nan)
  );
`else
  assign word     = bus.w_data;
  assign word_nan = 1'b0;
`endif

  assign slot_total = {2'b00, ks} * {2'b00, ks};
  assign cfg_ok     = (bus.kernel_size != 3'd0)
                   && (bus.kernel_size <= 3'(KERNEL_SIZE_MAX))
                   && (bus.slice_count != {WRITE_ADDR_WIDTH{1'b0}})
                   && (bus.slice_count <= WRITE_ADDR_WIDTH'(SLICE_MAX));
  assign accept     = (state == ST_LOAD) && bus.w_valid && bus.w_ready;
  assign last_word  = accept && ((elem_cnt + 5'd1) == slot_total);
  assign last_slice = (slice_idx == (slices - WRITE_ADDR_WIDTH'(1)));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (bus.start && cfg_ok) next_state = ST_LOAD;  else next_state = ST_IDLE;
      ST_LOAD:  if (last_word)           next_state = ST_WRITE; else next_state = ST_LOAD;
      ST_WRITE: if (last_slice)          next_state = ST_DONE;  else next_state = ST_LOAD;
      ST_DONE:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Slice buffer with the word being accepted this cycle already merged in
  always_comb begin
    buffer_next = buffer;
    if (accept) begin
      buffer_next[{elem_cnt, 4'b0000} +: DATA_WIDTH] = word;
    end else begin
      buffer_next = buffer;
    end
  end

  // Job configuration, counters, slice buffer and sticky NaN flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ks           <= 3'd0;
      slices       <= {WRITE_ADDR_WIDTH{1'b0}};
      slice_idx    <= {WRITE_ADDR_WIDTH{1'b0}};
      elem_cnt     <= 5'd0;
      buffer       <= {DIN_WIDTH{1'b0}};
      bus.nan_seen <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start && cfg_ok) begin
            ks           <= bus.kernel_size;
            slices       <= bus.slice_count;
            slice_idx    <= {WRITE_ADDR_WIDTH{1'b0}};
            elem_cnt     <= 5'd0;
            buffer       <= {DIN_WIDTH{1'b0}};
            bus.nan_seen <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (accept) begin
            buffer   <= buffer_next;
            elem_cnt <= elem_cnt + 5'd1;
            if (word_nan) bus.nan_seen <= 1'b1;
          end
        end
        ST_WRITE: begin
          if (!last_slice) begin
            slice_idx <= slice_idx + WRITE_ADDR_WIDTH'(1);
            elem_cnt  <= 5'd0;
            buffer    <= {DIN_WIDTH{1'b0}};
          end
        end
        ST_DONE: begin
          elem_cnt <= 5'd0;
        end
        default: begin
          elem_cnt <= 5'd0;
        end
      endcase
    end
  end

  // Outputs registered from the next state so they line up with the state they describe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.w_ready    <= 1'b0;
      bus.ena_wr     <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.addr_write <= {WRITE_ADDR_WIDTH{1'b0}};
      bus.din        <= {DIN_WIDTH{1'b0}};
    end else begin
      bus.w_ready <= (next_state == ST_LOAD);
      bus.ena_wr  <= (next_state == ST_WRITE);
      bus.busy    <= (next_state != ST_IDLE);
      bus.done    <= (next_state == ST_DONE);
      if (next_state == ST_WRITE) begin
        bus.addr_write <= slice_idx;
        bus.din        <= buffer_next;
      end
    end
  end

endmodule

// File: tb/tb_weight_slice_packer.sv
// Randomized self-checking bench for weight_slice_packer against a slot-level reference model.
// Honors WEIGHT_PACK_NAN_FLUSH_EN in the model when the macro is defined for the build.
module tb_weight_slice_packer;
  import weight_slice_packer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  weight_slice_packer_if bus_if();

  weight_slice_packer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [15:0]                 words[$];
  logic [WRITE_ADDR_WIDTH-1:0] wr_addr_q[$];
  logic [DIN_WIDTH-1:0]        wr_din_q[$];
  int                          wr_cyc_q[$];
  int                          done_cyc_q[$];
  int                          acc_cyc_q[$];
  bit                          busy_seen;

  task automatic check_eq(input string tag, input logic [DIN_WIDTH-1:0] got, input logic [DIN_WIDTH-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Observe the DUT mid-cycle: write pulses, done pulses and stream acceptances
  always @(negedge clk) begin
    if (bus_if.ena_wr === 1'b1) begin
      wr_addr_q.push_back(bus_if.addr_write);
      wr_din_q.push_back(bus_if.din);
      wr_cyc_q.push_back(cyc);
      check_eq("wready_low_in_write", bus_if.w_ready, 1'b0);
    end
    if (bus_if.done === 1'b1) done_cyc_q.push_back(cyc);
    if (!rst && bus_if.w_valid && bus_if.w_ready) acc_cyc_q.push_back(cyc);
    if (bus_if.busy === 1'b1) busy_seen = 1'b1;
  end

  function automatic bit ref_is_nan(input logic [15:0] w);
    return (w[14:10] == 5'h1F) && (w[9:0] != 10'd0);
  endfunction

  function automatic logic [15:0] ref_store(input logic [15:0] w);
`ifdef WEIGHT_PACK_NAN_FLUSH_EN
    if (ref_is_nan(w)) return 16'h0000;
`endif
    return w;
  endfunction

  function automatic logic [DIN_WIDTH-1:0] ref_slice(input int ks, input int s);
    logic [DIN_WIDTH-1:0] d = '0;
    for (int k = 0; k < ks * ks; k++) d[k*16 +: 16] = ref_store(words[s*ks*ks + k]);
    return d;
  endfunction

  function automatic logic ref_nan_flag(input int total);
    logic f = 1'b0;
`ifdef WEIGHT_PACK_NAN_FLUSH_EN
    for (int i = 0; i < total; i++) if (ref_is_nan(words[i])) f = 1'b1;
`endif
    return f;
  endfunction

  task automatic clear_obs();
    wr_addr_q.delete(); wr_din_q.delete(); wr_cyc_q.delete();
    done_cyc_q.delete(); acc_cyc_q.delete(); busy_seen = 1'b0;
  endtask

  task automatic start_job(input int ks, input int sc);
    @(posedge clk); #1;
    bus_if.start = 1'b1; bus_if.kernel_size = ks[2:0]; bus_if.slice_count = sc[4:0];
    @(posedge clk); #1;
    bus_if.start = 1'b0;
  endtask

  // mode: 0 always valid, 1 valid every other cycle, 2 random valid
  task automatic feed(input int target, input int mode, input int busy_start_at);
    int idx = 0;
    int budget = 0;
    bit v, acc;
    while (idx < target && budget < 3000) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (budget % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      bus_if.w_valid = v;
      bus_if.w_data  = v ? words[idx] : 16'($urandom);
      if (idx == busy_start_at) begin
        bus_if.start = 1'b1; bus_if.kernel_size = 3'd5; bus_if.slice_count = 5'd1;
      end else begin
        bus_if.start = 1'b0;
      end
      acc = v && bus_if.w_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      budget++;
    end
    bus_if.w_valid = 1'b0;
    bus_if.start   = 1'b0;
    check_eq("feed_complete", idx, target);
  endtask

  task automatic run_and_check(input int ks, input int sc, input int mode, input int busy_start_at);
    int n = ks * ks;
    int w = 0;
    int nw;
    clear_obs();
    start_job(ks, sc);
    check_eq("nan_clear_on_start", bus_if.nan_seen, 1'b0);
    check_eq("busy_after_start", bus_if.busy, 1'b1);
    feed(sc * n, mode, busy_start_at);
    while (done_cyc_q.size() == 0 && w < 100) begin
      @(posedge clk); #1; w++;
    end
    @(posedge clk); #1;
    nw = wr_cyc_q.size();
    check_eq("write_count", nw, sc);
    check_eq("accept_count", acc_cyc_q.size(), sc * n);
    for (int s = 0; s < nw && s < sc; s++) begin
      check_eq("addr_write", wr_addr_q[s], s);
      check_eq("din_slots", wr_din_q[s], ref_slice(ks, s));
      if ((s + 1) * n - 1 < acc_cyc_q.size())
        check_eq("write_latency", wr_cyc_q[s], acc_cyc_q[(s + 1) * n - 1] + 1);
    end
    check_eq("done_count", done_cyc_q.size(), 1);
    if (done_cyc_q.size() > 0 && nw > 0)
      check_eq("done_after_write", done_cyc_q[0], wr_cyc_q[nw - 1] + 1);
    check_eq("busy_idle_at_end", bus_if.busy, 1'b0);
    check_eq("nan_seen", bus_if.nan_seen, ref_nan_flag(sc * n));
  endtask

  task automatic fill_words(input int total, input bit with_nans);
    words.delete();
    for (int i = 0; i < total; i++) begin
      if (with_nans && $urandom_range(0, 3) == 0)
        words.push_back({1'($urandom), 5'h1F, 10'($urandom_range(0, 3))});
      else
        words.push_back(16'($urandom));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ready_ena_busy_done"},
             {bus_if.w_ready, bus_if.ena_wr, bus_if.busy, bus_if.done, bus_if.nan_seen}, 5'b00000);
    check_eq({tag, "_addr"}, bus_if.addr_write, 5'd0);
    check_eq({tag, "_din"}, bus_if.din, '0);
  endtask

  initial begin
    int bad_ks[4] = '{0, 6, 3, 3};
    int bad_sc[4] = '{1, 1, 0, 5};
    int ks, sc;
    rst = 1'b1;
    bus_if.start = 1'b0; bus_if.kernel_size = 3'd0; bus_if.slice_count = 5'd0;
    bus_if.w_valid = 1'b0; bus_if.w_data = 16'h0000;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1 check_reset_outputs("post_reset");

    words.delete();
    for (int i = 0; i < 18; i++) words.push_back(16'h3C00 + 16'(i));
    run_and_check(3, 2, 0, -1);

    fill_words(25, 1'b0);
    run_and_check(5, 1, 1, -1);

    for (int i = 0; i < 4; i++) begin
      clear_obs();
      start_job(bad_ks[i], bad_sc[i]);
      repeat (4) @(posedge clk);
      #1;
      check_eq("invalid_start_busy", busy_seen, 1'b0);
      check_eq("invalid_start_writes", wr_cyc_q.size() + done_cyc_q.size(), 0);
    end

    fill_words(9, 1'b0);
    clear_obs();
    start_job(3, 1);
    feed(4, 0, -1);
    rst = 1'b1;
    #1 check_reset_outputs("async_reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_eq("no_write_after_abort", wr_cyc_q.size() + done_cyc_q.size(), 0);
    fill_words(18, 1'b0);
    run_and_check(3, 2, 2, -1);

    fill_words(8, 1'b0);
    run_and_check(2, 2, 0, 2);

    words.delete();
    words.push_back(16'h7E00); words.push_back(16'h7C00);
    words.push_back(16'h3C00); words.push_back(16'hFE01);
    run_and_check(2, 1, 0, -1);
    fill_words(1, 1'b0);
    run_and_check(1, 1, 0, -1);

    for (int j = 0; j < 6; j++) begin
      ks = $urandom_range(1, 5);
      sc = $urandom_range(1, 4);
      fill_words(ks * ks * sc, 1'b1);
      run_and_check(ks, sc, 2, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
